// File: rtl/delay_bram_d_pkg.sv
// Shared defaults and the delay-range check for the BRAM delay line.
package delay_bram_d_pkg;

  localparam int DATA_W_DEF = 36;
  localparam int ADDR_W_DEF = 9;
  localparam int DELAY_MIN  = 2;

  function automatic bit delay_legal(input int delay, input int addr_w);
    return (delay >= DELAY_MIN) && (delay <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/delay_bram_d_if.sv
// Sample-stream bundle: producer drives ena/din/sync_in, the delay line returns the delayed stream.
interface delay_bram_d_if
  import delay_bram_d_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              ena;
  logic [DATA_W-1:0] din;
  logic              sync_in;
  logic [DATA_W-1:0] dout;
  logic              sync_out;
  logic              primed;

  modport master (output ena, din, sync_in, input dout, sync_out, primed);
  modport slave  (input ena, din, sync_in, output dout, sync_out, primed);
endinterface

// File: rtl/delay_bram_d_counter.sv
// Generic wrapping counter used as the RAM address generator.
module counter_d #(
  parameter int WIDTH     = 9,
  parameter int MIN_COUNT = 0,
  parameter int MAX_COUNT = 511,
  parameter int STEP      = 1,
  parameter bit COUNT_UP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_COUNT);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (COUNT_UP) begin
      count_next = (count_reg == MAX_V) ? MIN_V : count_reg + STEP_V;
    end else begin
      count_next = (count_reg == MIN_V) ? MAX_V : count_reg - STEP_V;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= COUNT_UP ? MIN_V : MAX_V;
    end else if (ena) begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
endmodule

// File: rtl/delay_bram_d.sv
// Fixed-length delay line on an inferred single-port read-before-write RAM,
// with a fill counter that masks stale RAM contents until DELAY samples are stored.
module delay_bram_d
  import delay_bram_d_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DELAY  = 512
) (
  input  logic           clk,
  input  logic           rst,
  delay_bram_d_if.slave  bus
);
  generate
    if (!delay_legal(DELAY, ADDR_W)) begin : g_bad_delay
      $error("delay_bram_d: DELAY=%0d outside 2..2**ADDR_W (ADDR_W=%0d)", DELAY, ADDR_W);
    end
  endgenerate

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FILL_MAX  = (ADDR_W + 1)'(DELAY);
  localparam logic [ADDR_W:0] FILL_LAST = (ADDR_W + 1)'(DELAY - 1);
  localparam logic [ADDR_W:0] FILL_ONE  = (ADDR_W + 1)'(1);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W:0]   ram [0:DEPTH-1];
  logic [DATA_W:0]   rd_reg;
  logic [ADDR_W:0]   fill_reg;
  logic              primed_reg;

  counter_d #(
    .WIDTH     (ADDR_W),
    .MIN_COUNT (0),
    .MAX_COUNT (DELAY - 1),
    .STEP      (1),
    .COUNT_UP  (1'b1)
  ) u_addr (
    .clk   (clk),
    .rst   (rst),
    .ena   (bus.ena),
    .count (addr)
  );

  // RAM is never reset; the primed gate below hides its power-up contents.
  always_ff @(posedge clk) begin
    if (bus.ena) begin
      ram[addr] <= {bus.sync_in, bus.din};
    end
  end

  // The old primed value selects the source, so the edge that completes the fill still emits 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_reg     <= '0;
      fill_reg   <= '0;
      primed_reg <= 1'b0;
    end else if (bus.ena) begin
      rd_reg     <= primed_reg ? ram[addr] : '0;
      primed_reg <= (fill_reg >= FILL_LAST);
      if (fill_reg != FILL_MAX) begin
        fill_reg <= fill_reg + FILL_ONE;
      end
    end
  end

  assign bus.dout     = rd_reg[DATA_W-1:0];
  assign bus.sync_out = rd_reg[DATA_W];
  assign bus.primed   = primed_reg;
endmodule

// File: tb/tb_delay_bram_d.sv
// Drives three delay lines (DELAY 4, 2, 512) and compares against a queue-based reference.
module tb_delay_bram_d;
  localparam int DW = 36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  delay_bram_d_if #(.DATA_W(DW)) bus4 ();
  delay_bram_d_if #(.DATA_W(DW)) bus2 ();
  delay_bram_d_if #(.DATA_W(DW)) bus512 ();

  delay_bram_d #(.DATA_W(DW), .ADDR_W(9), .DELAY(4))   u4   (.clk(clk), .rst(rst), .bus(bus4));
  delay_bram_d #(.DATA_W(DW), .ADDR_W(9), .DELAY(2))   u2   (.clk(clk), .rst(rst), .bus(bus2));
  delay_bram_d #(.DATA_W(DW), .ADDR_W(9), .DELAY(512)) u512 (.clk(clk), .rst(rst), .bus(bus512));

  logic          ena_v  [3];
  logic [DW-1:0] din_v  [3];
  logic          sync_v [3];
  logic [DW-1:0] obs_d  [3];
  logic          obs_s  [3];
  logic          obs_p  [3];

  assign bus4.ena   = ena_v[0];  assign bus4.din   = din_v[0];  assign bus4.sync_in   = sync_v[0];
  assign bus2.ena   = ena_v[1];  assign bus2.din   = din_v[1];  assign bus2.sync_in   = sync_v[1];
  assign bus512.ena = ena_v[2];  assign bus512.din = din_v[2];  assign bus512.sync_in = sync_v[2];
  assign obs_d[0] = bus4.dout;   assign obs_s[0] = bus4.sync_out;   assign obs_p[0] = bus4.primed;
  assign obs_d[1] = bus2.dout;   assign obs_s[1] = bus2.sync_out;   assign obs_p[1] = bus2.primed;
  assign obs_d[2] = bus512.dout; assign obs_s[2] = bus512.sync_out; assign obs_p[2] = bus512.primed;

  int          dly [3] = '{4, 2, 512};
  logic [DW:0] q     [3][$];
  logic [DW:0] exp_w [3];
  int          nena  [3];
  int          total = 0;
  int          bad   = 0;
  int          k4;

  task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      nena[i]  = 0;
      exp_w[i] = '0;
    end
  endtask

  // Reference: every enabled sample enters a FIFO; once it holds more than DELAY, the oldest leaves.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (ena_v[i]) begin
          q[i].push_back({sync_v[i], din_v[i]});
          nena[i]++;
          if (q[i].size() > dly[i]) exp_w[i] = q[i].pop_front();
          else                      exp_w[i] = '0;
        end
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d_data_n%0d", dly[i], nena[i]), {obs_s[i], obs_d[i]}, exp_w[i]);
      check($sformatf("d%0d_primed_n%0d", dly[i], nena[i]), {{DW{1'b0}}, obs_p[i]},
            {{DW{1'b0}}, (nena[i] >= dly[i])});
    end
    $display("cyc t=%0t d4=%h/%0b d2=%h/%0b d512=%h/%0b", $time,
             {obs_s[0], obs_d[0]}, obs_p[0], {obs_s[1], obs_d[1]}, obs_p[1],
             {obs_s[2], obs_d[2]}, obs_p[2]);
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      ena_v[i] = 1'b0; din_v[i] = '0; sync_v[i] = 1'b0;
    end
    reset_model();
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("d%0d_reset_state", dly[i]), {obs_p[i], obs_s[i], obs_d[i][DW-2:0]}, '0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;

    // Continuous enable: DELAY=4 sees 1,2,3,...; DELAY=512 gets a sync every 512 samples.
    for (int k = 1; k <= 24; k++) begin
      for (int i = 0; i < 3; i++) ena_v[i] = 1'b1;
      din_v[0] = DW'(k);          sync_v[0] = 1'b0;
      din_v[1] = rnd();           sync_v[1] = $urandom_range(1, 0) == 1;
      din_v[2] = rnd();           sync_v[2] = (nena[2] % 512) == 0;
      tick();
    end

    // Alternating / random enable.
    for (int k = 0; k < 24; k++) begin
      ena_v[0] = (k % 2) == 0;    din_v[0] = DW'(100 + k);
      ena_v[1] = $urandom_range(1, 0) == 1; din_v[1] = rnd();
      ena_v[2] = 1'b1;            din_v[2] = rnd();   sync_v[2] = (nena[2] % 512) == 0;
      tick();
    end

    // Reset pulse between edges must clear outputs without waiting for a clock.
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("d%0d_async_reset", dly[i]), {obs_p[i], obs_s[i], obs_d[i][DW-2:0]}, '0);
    reset_model();
    tick();
    #2 rst = 1'b0;

    k4 = 0;
    for (int k = 0; k < 2100; k++) begin
      ena_v[0] = $urandom_range(3, 0) != 0;
      if (ena_v[0]) k4++;
      din_v[0] = DW'(1000 + k4);  sync_v[0] = $urandom_range(1, 0) == 1;
      ena_v[1] = $urandom_range(1, 0) == 1; din_v[1] = rnd(); sync_v[1] = $urandom_range(1, 0) == 1;
      ena_v[2] = (k % 97) != 50;  din_v[2] = rnd();   sync_v[2] = (nena[2] % 512) == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
